// File: rtl/lrf_fuse_sequencer.sv
// Input sequencer for the LRF fusion core: frames beats into images and batches, regenerates tlast.
// Define LRF_SEQ_ERR_STATS_EN to add the err_count/batch_count statistics outputs.
module lrf_fuse_sequencer #(
    parameter int PIXELS_PER_BEAT = 8,
    parameter int IMAGE_DIM       = 16,
    parameter int N_FUSE_COUNT    = 4,
    localparam int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    localparam int BEATS_PER_IMAGE = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
    localparam int FW              = $clog2(N_FUSE_COUNT)
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [FW-1:0]         frame_idx,
    output logic                  batch_last,
    output logic                  batch_done,
    output logic                  err_tlast,
`ifdef LRF_SEQ_ERR_STATS_EN
    output logic [15:0]           err_count,
    output logic [15:0]           batch_count,
`endif
    output logic                  busy
);

    localparam int BW = (BEATS_PER_IMAGE > 1) ? $clog2(BEATS_PER_IMAGE) : 1;
    localparam logic [BW-1:0] BEAT_MAX  = BW'(BEATS_PER_IMAGE - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(N_FUSE_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BW-1:0]         r_beat_cnt;
    logic [FW-1:0]         r_frame_cnt;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [FW-1:0]         r_frame_idx;
    logic                  r_batch_last;
    logic                  r_err_tlast;

    logic w_beat_last;
    logic w_frame_last;
    logic w_at_bound;
    logic w_out_free;
    logic w_s_ready;
    logic w_s_acc;
    logic w_m_acc;

    assign w_beat_last  = (r_beat_cnt == BEAT_MAX);
    assign w_frame_last = (r_frame_cnt == FRAME_MAX);
    assign w_at_bound   = (r_beat_cnt == '0) && (r_frame_cnt == '0);
    assign w_out_free   = ~r_m_tvalid | m_tready;

    // At a batch boundary, only a live enable lets the next batch start.
    assign w_s_ready = (r_state != S_IDLE) & w_out_free & ~(w_at_bound & ~enable);
    assign w_s_acc   = s_tvalid & w_s_ready;
    assign w_m_acc   = r_m_tvalid & m_tready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!enable) begin
                    w_state_nxt = (w_at_bound && !r_m_tvalid) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                end else if (w_at_bound && w_out_free) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Framing follows accepted beats only; upstream tlast never resyncs it.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_beat_cnt  <= '0;
            r_frame_cnt <= '0;
        end else if (w_s_acc) begin
            if (w_beat_last) begin
                r_beat_cnt  <= '0;
                r_frame_cnt <= w_frame_last ? '0 : r_frame_cnt + 1'b1;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tdata    <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_frame_idx  <= '0;
            r_batch_last <= 1'b0;
            r_err_tlast  <= 1'b0;
        end else begin
            r_err_tlast <= w_s_acc & (s_tlast != w_beat_last);
            if (w_s_acc) begin
                r_m_tdata    <= s_tdata;
                r_m_tvalid   <= 1'b1;
                r_m_tlast    <= w_beat_last;
                r_frame_idx  <= r_frame_cnt;
                r_batch_last <= w_beat_last & w_frame_last;
            end else if (w_m_acc) begin
                r_m_tvalid   <= 1'b0;
                r_m_tlast    <= 1'b0;
                r_batch_last <= 1'b0;
            end
        end
    end

`ifdef LRF_SEQ_ERR_STATS_EN
    logic [15:0] r_err_count;
    logic [15:0] r_batch_count;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_err_count   <= '0;
            r_batch_count <= '0;
        end else begin
            if (r_err_tlast && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
            if (w_m_acc && r_batch_last) begin
                r_batch_count <= r_batch_count + 16'd1;
            end
        end
    end

    assign err_count   = r_err_count;
    assign batch_count = r_batch_count;
`endif

    assign s_tready   = w_s_ready;
    assign m_tdata    = r_m_tdata;
    assign m_tvalid   = r_m_tvalid;
    assign m_tlast    = r_m_tlast;
    assign frame_idx  = r_frame_idx;
    assign batch_last = r_batch_last;
    assign batch_done = w_m_acc & r_batch_last;
    assign err_tlast  = r_err_tlast;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_lrf_fuse_sequencer.sv
// Scoreboard bench for lrf_fuse_sequencer: expected beats are queued on input
// acceptance and checked by an independent output monitor.
module tb_lrf_fuse_sequencer;

    localparam int PPB    = 8;
    localparam int DW     = 64;
    localparam int BPI    = 32;
    localparam int NF     = 4;
    localparam int BPB    = BPI * NF;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic [1:0]    frame_idx;
    logic          batch_last;
    logic          batch_done;
    logic          err_tlast;
    logic          busy;
`ifdef LRF_SEQ_ERR_STATS_EN
    logic [15:0]   err_count;
    logic [15:0]   batch_count;
`endif

    lrf_fuse_sequencer dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .enable     (enable),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .frame_idx  (frame_idx),
        .batch_last (batch_last),
        .batch_done (batch_done),
        .err_tlast  (err_tlast),
`ifdef LRF_SEQ_ERR_STATS_EN
        .err_count  (err_count),
        .batch_count(batch_count),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [1:0]    fidx;
        logic          blast;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   k = 0;
    bit   pend = 1'b0;
    int   n_bd = 0;
    int   n_err = 0;
    int   seen_bd = 0;
    int   seen_err = 0;
    int   cyc = 0;
    bit   rnd_ready = 1'b0;
    int   drv_g = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference model: the k-th accepted beat since reset is framed purely by k.
    always @(negedge clk) begin
        exp_t e;
        if (!aresetn) begin
            q.delete();
            k = 0;
            pend = 1'b0;
            n_err = 0;
        end else begin
            total++;
            if (err_tlast !== pend) begin
                bad++;
                $display("FAIL err_tlast got=%0b exp=%0b k=%0d", err_tlast, pend, k);
            end
            if (err_tlast === 1'b1) seen_err++;
            pend = 1'b0;
            if (s_tvalid && s_tready) begin
                e.data  = s_tdata;
                e.last  = (k % BPI) == BPI - 1;
                e.fidx  = 2'((k / BPI) % NF);
                e.blast = (k % BPB) == BPB - 1;
                pend    = (s_tlast != e.last);
                if (pend) n_err++;
                q.push_back(e);
                k++;
            end
        end
    end

    exp_t hold;
    bit   stall = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        logic bd_exp;
        if (!aresetn) begin
            stall = 1'b0;
            n_bd = 0;
            total++;
            if ({m_tvalid, m_tlast, batch_last, batch_done, err_tlast, busy,
                 s_tready, frame_idx, m_tdata} !== '0) begin
                bad++;
                $display("FAIL reset_state got v=%0b l=%0b bl=%0b bd=%0b e=%0b busy=%0b rdy=%0b f=%0d d=%h exp all zero",
                         m_tvalid, m_tlast, batch_last, batch_done, err_tlast, busy, s_tready, frame_idx, m_tdata);
            end
        end else begin
            if (stall) begin
                total++;
                if ({m_tvalid, m_tdata, m_tlast, frame_idx, batch_last} !==
                    {1'b1, hold.data, hold.last, hold.fidx, hold.blast}) begin
                    bad++;
                    $display("FAIL stall_hold got v=%0b d=%h exp d=%h", m_tvalid, m_tdata, hold.data);
                end
            end
            bd_exp = 1'b0;
            if (m_tvalid && m_tready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat got d=%h exp none", m_tdata);
                end else begin
                    e = q.pop_front();
                    bd_exp = e.blast;
                    if (e.blast) n_bd++;
                    if ({m_tdata, m_tlast, frame_idx, batch_last} !==
                        {e.data, e.last, e.fidx, e.blast}) begin
                        bad++;
                        $display("FAIL beat got d=%h l=%0b f=%0d bl=%0b exp d=%h l=%0b f=%0d bl=%0b",
                                 m_tdata, m_tlast, frame_idx, batch_last,
                                 e.data, e.last, e.fidx, e.blast);
                    end
                end
            end
            total++;
            if (batch_done !== bd_exp) begin
                bad++;
                $display("FAIL batch_done got=%0b exp=%0b", batch_done, bd_exp);
            end
            if (batch_done === 1'b1) seen_bd++;
            stall = m_tvalid && !m_tready;
            hold.data  = m_tdata;
            hold.last  = m_tlast;
            hold.fidx  = frame_idx;
            hold.blast = batch_last;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input bit rnd, input bit gaps, input int err_at);
        for (int i = 0; i < n; i++) begin
            int t;
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            for (int j = 0; j < PPB; j++) begin
                s_tdata[j*8 +: 8] = rnd ? 8'($urandom) : 8'(drv_g * 8 + j);
            end
            s_tlast  = ((drv_g % BPI) == BPI - 1) || (drv_g == err_at);
            s_tvalid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!s_tready && t < BUDGET) begin
                @(negedge clk);
                t++;
            end
            if (!s_tready) begin
                total++;
                bad++;
                $display("FAIL send_timeout got no s_tready exp accept beat=%0d", drv_g);
                s_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            drv_g++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < BUDGET) begin
            @(posedge clk);
            t++;
        end
        idle(2);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got left=%0d exp 0", q.size());
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    initial begin
        int bd0;
        int er0;
        int c0;
        int t;

        idle(3);
        aresetn = 1'b1;
        idle(1);
        check_int("idle_ready", int'(s_tready), 0);

        // Straight stream, one full batch
        enable = 1'b1;
        bd0 = seen_bd;
        er0 = seen_err;
        send(BPB, 1'b0, 1'b0, -1);
        wait_drain();
        check_int("t1_batch_done", seen_bd - bd0, 1);
        check_int("t1_err", seen_err - er0, 0);

        // Random backpressure and input gaps, two batches
        rnd_ready = 1'b1;
        bd0 = seen_bd;
        send(2 * BPB, 1'b1, 1'b1, -1);
        rnd_ready = 1'b0;
        idle(1);
        wait_drain();
        check_int("t2_batch_done", seen_bd - bd0, 2);

        // Enable drops at beat 40: batch still completes, then stop
        bd0 = seen_bd;
        send(41, 1'b1, 1'b0, -1);
        enable = 1'b0;
        send(BPB - 41, 1'b1, 1'b0, -1);
        s_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_int("drain_ready_low", int'(s_tready), 0);
        end
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_int("drain_busy_low", int'(busy), 0);
        s_tvalid = 1'b0;
        idle(1);
        wait_drain();
        check_int("t4_batch_done", seen_bd - bd0, 1);
        check_int("t4_tvalid_low", int'(m_tvalid), 0);

        // Reset mid-batch at beat 70, then a fresh batch
        enable = 1'b1;
        idle(1);
        send(70, 1'b1, 1'b0, -1);
        aresetn = 1'b0;
        drv_g = 0;
        idle(3);
        aresetn = 1'b1;
        rnd_ready = 1'b1;
        bd0 = seen_bd;
        send(BPB, 1'b1, 1'b1, -1);
        rnd_ready = 1'b0;
        idle(1);
        wait_drain();
        check_int("t5_batch_done", seen_bd - bd0, 1);

        // Early upstream tlast at beat 29 of image 0
        er0 = seen_err;
        send(BPB, 1'b0, 1'b0, drv_g + 29);
        wait_drain();
        check_int("t3_err_pulses", seen_err - er0, 1);

        // Three back-to-back batches with no bubble
        bd0 = seen_bd;
        c0 = cyc;
        send(3 * BPB, 1'b1, 1'b0, -1);
        check_int("t6_cycles", cyc - c0, 3 * BPB);
        wait_drain();
        check_int("t6_batch_done", seen_bd - bd0, 3);

`ifdef LRF_SEQ_ERR_STATS_EN
        check_int("err_count", int'(err_count), n_err);
        check_int("batch_count", int'(batch_count), n_bd);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
